// File: rtl/proc_element_pipe.sv
// rtl/proc_element_pipe.sv - 3-stage flow-controlled 3x3 RGB window processor (point ops, kernels, grayscale).
// Optional macro PE_SAT_CNT_EN adds sat_cnt, a saturating count of emitted pixels that clamped.
module proc_element_pipe #(
   parameter int CH_W        = 4,
   parameter int BRIGHT_STEP = 2,
   parameter int CNT_W       = 17,
   localparam int PIX_W      = 3*CH_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2:0]         func,
   input  logic               gray,
   input  logic               done_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3*PIX_W-1:0] win_row0,
   input  logic [3*PIX_W-1:0] win_row1,
   input  logic [3*PIX_W-1:0] win_row2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PIX_W-1:0]   data_out,
   output logic               busy,
   output logic               done_out,
   output logic [CNT_W-1:0]   pix_cnt
`ifdef PE_SAT_CNT_EN
   ,
   output logic [15:0]        sat_cnt
`endif
);

   localparam int ACC_W = CH_W + 5;
   localparam logic signed [ACC_W-1:0] MAX_ACC  = ACC_W'((1 << CH_W) - 1);
   localparam logic signed [ACC_W-1:0] STEP_ACC = ACC_W'(BRIGHT_STEP);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_DRAIN = 2'b10;

   logic [1:0]               state;
   logic [2:0]               func_q;
   logic                     gray_q;
   logic                     s1_valid, s2_valid;
   logic [3*PIX_W-1:0]       win_raw [3];
   logic [3*PIX_W-1:0]       in_row  [3];
   logic [3*PIX_W-1:0]       s1_row  [3];
   logic [9*CH_W-1:0]        chan_win [3];
   logic signed [ACC_W-1:0]  s2_acc_d [3];
   logic signed [ACC_W-1:0]  s2_acc   [3];
   logic [PIX_W-1:0]         s3_pix;
   logic                     s3_sat;
   logic                     advance, accept, emit;

   function automatic logic [PIX_W-1:0] to_gray(input logic [PIX_W-1:0] p);
      logic [CH_W+1:0] s;
      s = {2'b00, p[PIX_W-1 -: CH_W]} + {1'b0, p[CH_W +: CH_W], 1'b0} + {2'b00, p[CH_W-1:0]};
      return {3{s[CH_W+1:2]}};
   endfunction

   // w holds one channel of the window, index = row*3 + col; centre is index 4
   function automatic logic signed [ACC_W-1:0] op_chan(input logic [9*CH_W-1:0] w,
                                                      input logic [2:0] f);
      logic signed [ACC_W-1:0] a [9];
      logic signed [ACC_W-1:0] orth, corn, res;
      for (int i = 0; i < 9; i++)
         a[i] = $signed({{(ACC_W-CH_W){1'b0}}, w[i*CH_W +: CH_W]});
      orth = a[1] + a[3] + a[5] + a[7];
      corn = a[0] + a[2] + a[6] + a[8];
      case (f)
         3'b000:  res = a[4];
         3'b001:  res = MAX_ACC - a[4];
         3'b010:  res = a[4] + STEP_ACC;
         3'b011:  res = a[4] - STEP_ACC;
         3'b100:  res = (corn + (orth <<< 1) + (a[4] <<< 2)) >>> 4;
         3'b101:  res = (a[4] <<< 2) + a[4] - orth;
         3'b110:  res = (a[4] <<< 3) - orth - corn;
         default: res = (orth + corn) >>> 3;
      endcase
      return res;
   endfunction

   assign advance  = ~out_valid | out_ready;
   assign in_ready = (state == ST_RUN) & advance;
   assign accept   = in_valid & in_ready;
   assign emit     = out_valid & out_ready;
   assign busy     = (state != ST_IDLE);

   assign win_raw[0] = win_row0;
   assign win_raw[1] = win_row1;
   assign win_raw[2] = win_row2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         func_q   <= 3'b000;
         gray_q   <= 1'b0;
         pix_cnt  <= '0;
         done_out <= 1'b0;
      end else begin
         done_out <= 1'b0;
         if (emit)
            pix_cnt <= pix_cnt + 1'b1;
         case (state)
            ST_IDLE: if (start) begin
               state   <= ST_RUN;
               func_q  <= func;
               gray_q  <= gray;
               pix_cnt <= '0;
            end
            ST_RUN: if (done_in)
               state <= ST_DRAIN;
            ST_DRAIN: if (!s1_valid && !s2_valid && advance) begin
               state    <= ST_IDLE;
               done_out <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         in_row[r] = win_raw[r];
         if (gray_q)
            for (int k = 0; k < 3; k++)
               in_row[r][k*PIX_W +: PIX_W] = to_gray(win_raw[r][k*PIX_W +: PIX_W]);
      end
   end

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         chan_win[c] = '0;
         for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
               chan_win[c][(r*3+k)*CH_W +: CH_W] = s1_row[r][k*PIX_W + c*CH_W +: CH_W];
         s2_acc_d[c] = op_chan(chan_win[c], func_q);
      end
   end

   always_comb begin
      s3_pix = '0;
      s3_sat = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (s2_acc[c][ACC_W-1]) begin
            s3_pix[c*CH_W +: CH_W] = '0;
            s3_sat = 1'b1;
         end else if (s2_acc[c] > MAX_ACC) begin
            s3_pix[c*CH_W +: CH_W] = '1;
            s3_sat = 1'b1;
         end else begin
            s3_pix[c*CH_W +: CH_W] = s2_acc[c][CH_W-1:0];
         end
      end
   end

   // Data registers follow the global advance; only the valid bits need reset
   always_ff @(posedge clk) begin
      if (advance) begin
         s1_row <= in_row;
         s2_acc <= s2_acc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         data_out  <= '0;
      end else if (advance) begin
         s1_valid  <= accept;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid)
            data_out <= s3_pix;
      end
   end

`ifdef PE_SAT_CNT_EN
   logic out_sat;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_sat <= 1'b0;
         sat_cnt <= '0;
      end else begin
         if (advance && s2_valid)
            out_sat <= s3_sat;
         if (state == ST_IDLE && start)
            sat_cnt <= '0;
         else if (emit && out_sat && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
      end
   end
`else
   logic unused_sat;
   assign unused_sat = s3_sat;
`endif

endmodule

// File: tb/tb_proc_element_pipe.sv
// tb/tb_proc_element_pipe.sv - scoreboard testbench for proc_element_pipe (CH_W=4).
module tb_proc_element_pipe;

   localparam int CH_W  = 4;
   localparam int CNT_W = 17;
   localparam int PIX_W = 3*CH_W;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [2:0]         func = 3'b000;
   logic               gray = 1'b0;
   logic               done_in = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [3*PIX_W-1:0] win_row0 = '0, win_row1 = '0, win_row2 = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [PIX_W-1:0]   data_out;
   logic               busy;
   logic               done_out;
   logic [CNT_W-1:0]   pix_cnt;
`ifdef PE_SAT_CNT_EN
   logic [15:0]        sat_cnt;
`endif

   proc_element_pipe #(.CH_W(CH_W), .BRIGHT_STEP(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .func(func), .gray(gray),
      .done_in(done_in), .in_valid(in_valid), .in_ready(in_ready),
      .win_row0(win_row0), .win_row1(win_row1), .win_row2(win_row2),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .busy(busy), .done_out(done_out), .pix_cnt(pix_cnt)
`ifdef PE_SAT_CNT_EN
      , .sat_cnt(sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] pix;
      logic        sat;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         checks = 0;
   int         errors = 0;
   logic [2:0] m_func = 3'b000;
   logic       m_gray = 1'b0;
   int         exp_sat = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [35:0] r0, input logic [35:0] r1,
                                  input logic [35:0] r2, input logic [2:0] f, input logic g);
      logic [35:0] rows [3];
      int   px [3][3][3];
      int   v, ctr, nb_o, nb_c;
      exp_t e;
      rows = '{r0, r1, r2};
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++) begin
            logic [11:0] p;
            p = rows[r][k*12 +: 12];
            px[r][k][0] = int'(p[11:8]);
            px[r][k][1] = int'(p[7:4]);
            px[r][k][2] = int'(p[3:0]);
            if (g) begin
               v = (px[r][k][0] + 2*px[r][k][1] + px[r][k][2]) / 4;
               px[r][k][0] = v; px[r][k][1] = v; px[r][k][2] = v;
            end
         end
      e.pix = '0;
      e.sat = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         ctr  = px[1][1][ch];
         nb_o = px[0][1][ch] + px[1][0][ch] + px[1][2][ch] + px[2][1][ch];
         nb_c = px[0][0][ch] + px[0][2][ch] + px[2][0][ch] + px[2][2][ch];
         case (f)
            3'd0: v = ctr;
            3'd1: v = 15 - ctr;
            3'd2: v = ctr + 2;
            3'd3: v = ctr - 2;
            3'd4: v = (nb_c + 2*nb_o + 4*ctr) / 16;
            3'd5: v = 5*ctr - nb_o;
            3'd6: v = 8*ctr - nb_o - nb_c;
            default: v = (nb_o + nb_c) / 8;
         endcase
         if (v < 0) begin
            v = 0; e.sat = 1'b1;
         end else if (v > 15) begin
            v = 15; e.sat = 1'b1;
         end
         e.pix[(2-ch)*4 +: 4] = v[3:0];
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready)
         sb.push_back(model(win_row0, win_row1, win_row2, m_func, m_gray));
      if (rst_n && out_valid && out_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_output: observed 0x%0h with empty scoreboard, expected no output", data_out);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("data_out", 32'(data_out), 32'(mon_e.pix));
            if (mon_e.sat) exp_sat++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [2:0] f, input logic g);
      start = 1'b1; func = f; gray = g;
      m_func = f; m_gray = g; exp_sat = 0;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [35:0] r0, input logic [35:0] r1,
                       input logic [35:0] r2, input logic last);
      int got;
      got = 0;
      win_row0 = r0; win_row1 = r1; win_row2 = r2;
      in_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      chk("accept_seen", 32'(got), 32'd1);
      done_in = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      done_in  = 1'b0;
   endtask

   task automatic wait_out(input string tag, input logic [11:0] exp);
      int got;
      got = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1;
            break;
         end
      end
      chk({tag, "_valid_seen"}, 32'(got), 32'd1);
      chk(tag, 32'(data_out), 32'(exp));
   endtask

   task automatic wait_done(input string tag, input int exp_cnt);
      int got;
      got = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (done_out) begin
            got = 1;
            break;
         end
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      chk({tag, "_pix_cnt"}, 32'(pix_cnt), 32'(exp_cnt));
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
`ifdef PE_SAT_CNT_EN
      chk({tag, "_sat_cnt"}, 32'(sat_cnt), 32'(exp_sat));
`endif
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done_out), 32'd0);
   endtask

   function automatic logic [35:0] rnd_row();
      return {$urandom_range(4095, 0) & 12'hFFF,
              $urandom_range(4095, 0) & 12'hFFF,
              $urandom_range(4095, 0) & 12'hFFF};
   endfunction

   initial begin
      logic [35:0] w [10][3];
      logic [35:0] uni;
      logic [11:0] held;
      int          seen;

      repeat (3) tick();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_done_out", 32'(done_out), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      @(negedge clk);
      chk("idle_done_in_busy", 32'(busy), 32'd0);
      chk("idle_done_in_done_out", 32'(done_out), 32'd0);
      @(posedge clk); #1;

      start_job(3'b001, 1'b0);
      send(rnd_row(), {rnd_row()} & 36'hFFF_000_FFF | 36'h000_F00_000, rnd_row(), 1'b1);
      @(negedge clk);
      chk("lat_c1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_c2", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_c3", 32'(out_valid), 32'd1);
      chk("invert_pix", 32'(data_out), 32'h0FF);
      wait_done("invert", 1);

      start_job(3'b000, 1'b1);
      send(rnd_row(), {rnd_row()} & 36'hFFF_000_FFF | 36'h000_8C4_000, rnd_row(), 1'b1);
      wait_out("gray_copy", 12'h999);
      wait_done("gray", 1);

      uni = {3{12'h555}};
      start_job(3'b100, 1'b0);
      send(uni, uni, uni, 1'b1);
      wait_out("gauss_uniform", 12'h555);
      wait_done("gauss", 1);

      start_job(3'b110, 1'b0);
      send(uni, uni, uni, 1'b1);
      wait_out("lap_uniform", 12'h000);
      wait_done("lap_uni", 1);

      start_job(3'b110, 1'b0);
      send(36'h0, 36'h000_FFF_000, 36'h0, 1'b1);
      wait_out("lap_clamp", 12'hFFF);
      wait_done("lap_clamp", 1);
`ifdef PE_SAT_CNT_EN
      chk("lap_clamp_sat_cnt_one", 32'(sat_cnt), 32'd1);
`endif

      for (int i = 0; i < 10; i++)
         for (int r = 0; r < 3; r++)
            w[i][r] = rnd_row();
      start_job(3'b101, 1'b0);
      for (int i = 0; i < 5; i++)
         send(w[i][0], w[i][1], w[i][2], 1'b0);
      start = 1'b1;
      func  = 3'b001;
      send(w[5][0], w[5][1], w[5][2], 1'b0);
      start = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      held = data_out;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready_0", 32'(in_ready), 32'd0);
      for (int c = 1; c < 5; c++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_hold", 32'(data_out), 32'(held));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 6; i < 10; i++)
         send(w[i][0], w[i][1], w[i][2], i == 9);
      wait_done("backpressure", 10);

      start_job(3'b010, 1'b0);
      send(rnd_row(), rnd_row(), rnd_row(), 1'b0);
      send(rnd_row(), rnd_row(), rnd_row(), 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_pix_cnt", 32'(pix_cnt), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("midrst_no_output", 32'(seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
